cm0_dap_cdc_recv_hs: RTL
========================

# cm0_dap_cdc_recv_hs

Receive-side stage of the DAP four-phase clock-domain-crossing handshake. It consumes a request level and data bus driven from CDC-safe send registers in the remote domain. It synchronises the request, captures the data once it is stable, and offers the data to a local consumer on a valid/ready interface. It returns a glitch-free acknowledge level to the remote domain.

## Interface
- PRESENT, 1: when 0, the block is removed. All outputs are tied 0 and no state is retained.
- WIDTH, 32: data bus width (1–64).
- SYNC_STAGES, 2: flops in the REQIN synchroniser. Minimum 2; values below 2 are illegal.

Ports:
- REGCLK  in  1  local-domain clock
- RARREGRESET  in  1  asynchronous, active-high reset
- REQIN  in  1  request level from remote send register; asynchronous to REGCLK
- DATAIN  in  WIDTH  data from remote send registers; stable whenever REQIN is high and until ACKOUT is seen high remotely
- SE  in  1  scan enable; no functional effect; present for DFT hookup
- RREADY  in  1  local consumer ready
- ERRCLR  in  1  clears PROTERR
- RDATA  out  WIDTH  captured data, registered
- RVALID  out  1  RDATA valid, registered
- ACKOUT  out  1  acknowledge level to remote domain; driven directly from a flop with no logic after it
- PROTERR  out  1  sticky protocol-error flag, registered

## Operation
- Synchroniser: REQIN passes through SYNC_STAGES flops; its output is reqs. DATAIN is never synchronised and is sampled only when reqs=1.
- FSM states are IDLE, VALID and ACK. Reset state is IDLE.
- IDLE:
  - reqs=1: RDATA<=DATAIN, RVALID<=1, go to VALID.
  - Otherwise: hold.
- VALID:
  - reqs=0 (sender withdrew the request): PROTERR<=1, RVALID<=0, go to IDLE. The data is dropped and RREADY is ignored in that cycle.
  - Else if RREADY=1: RVALID<=0, ACKOUT<=1, go to ACK.
  - Otherwise: hold; RDATA is stable.
- ACK:
  - reqs=0: ACKOUT<=0, go to IDLE.
  - Otherwise: hold with ACKOUT=1, indefinitely if reqs stays high.
- ACKOUT is 1 only in ACK. RVALID is 1 only in VALID.
- RDATA updates only on the IDLE→VALID transition and otherwise holds its last value.
- PROTERR:
  - Set as described under VALID.
  - Cleared by ERRCLR=1 at a clock edge.
  - If set and clear occur in the same cycle, set wins.
- Remote-side rule: the next REQIN rise is legal only after ACKOUT has fallen. A reqs=1 seen in IDLE is always treated as a new request.
- Reset values: RDATA=0, RVALID=0, ACKOUT=0, PROTERR=0, all synchroniser flops=0.
- Reset mid-operation: the block returns to IDLE at once, asynchronously, and any in-flight transfer is discarded.
- PRESENT=0: RDATA, RVALID, ACKOUT and PROTERR are constant 0.

## Timing
Edges are REGCLK rising edges, with SYNC_STAGES=2.
- REQIN rises with setup met before edge E0:
  - reqs=1 after E1.
  - RVALID=1 and RDATA=DATAIN after E2.
  - Request-to-valid latency is SYNC_STAGES+1 edges.
- RVALID=1 and RREADY=1 at edge Ek:
  - RVALID=0 and ACKOUT=1 after Ek.
  - If RREADY is held high, RVALID lasts exactly one cycle.
- REQIN falls before edge En: reqs=0 after En+1, ACKOUT=0 after En+2.
- Minimum full transaction with RREADY tied high, local side only: 2·(SYNC_STAGES+1)+1 edges. Remote synchronisation of ACKOUT is extra.
- ACKOUT changes at most once per edge and never glitches between edges.
- All outputs are registered; no combinational path runs from any input to any output.

## Test plan
- Reset: assert RARREGRESET between edges → all outputs are 0 immediately, without waiting for a clock edge.
- Basic transfer, RREADY=1:
  - DATAIN=0xA5A5_1234, REQIN rises before E0 → RVALID=1, RDATA=0xA5A5_1234 after E2.
  - ACKOUT=1 after E3.
  - REQIN drops before E5 → ACKOUT=0 after E7.
  - PROTERR stays 0 throughout.
- Backpressure: RREADY=0 for 10 cycles after RVALID rises → RVALID and RDATA hold stable and ACKOUT stays 0. RREADY=1 → ACKOUT rises on the next edge.
- Protocol error: REQIN drops while in VALID, with RREADY=1 in the same cycle → PROTERR=1, RVALID=0, ACKOUT never rises.
  - ERRCLR pulse → PROTERR=0.
  - ERRCLR coinciding with a new error → PROTERR stays 1.
- Back-to-back: three transfers with data 0x1, 0x2, 0x3, each REQIN rising only after ACKOUT has fallen → exactly three RVALID handshakes with the data in order.
- Reset during ACK: RARREGRESET asserted while ACKOUT=1 and REQIN high → ACKOUT=0. After release, with REQIN still high, a new capture happens: RVALID=1 three edges after reset release.

Source files
------------

// File: rtl/cm0_dap_cdc_recv_hs.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_recv_hs
// Receive side of the DAP four-phase clock-domain-crossing handshake.
// REQIN is a level from a remote send register.  It is synchronised into
// REGCLK before the block acts on it.  DATAIN is held stable by the sender
// for the whole request phase, so it is captured directly once the
// synchronised request is seen.  The captured word is then offered on a
// valid/ready interface.  ACKOUT is returned to the remote domain straight
// from a flop, so the remote synchroniser never sees a glitch.
// A sender that withdraws its request before the local consumer accepts
// the data sets the sticky PROTERR flag.
// ---------------------------------------------------------------------------
module cm0_dap_cdc_recv_hs #(
  parameter int PRESENT     = 1,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             REGCLK,
  input  logic             RARREGRESET,
  input  logic             REQIN,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             SE,
  input  logic             RREADY,
  input  logic             ERRCLR,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  output logic             ACKOUT,
  output logic             PROTERR
);

  // A single-flop synchroniser is never acceptable on an asynchronous
  // level.  Any setting below two is therefore raised to two.
  localparam int L_SYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Handshake states, kept as plain encoded constants.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  generate
    if (PRESENT != 0) begin : g_present

      logic [L_SYNC-1:0] r_sync;
      logic              w_reqs;

      logic [1:0]        r_state;
      logic [1:0]        w_state_nxt;
      logic [WIDTH-1:0]  r_rdata;
      logic [WIDTH-1:0]  w_rdata_nxt;
      logic              r_rvalid;
      logic              w_rvalid_nxt;
      logic              r_ackout;
      logic              w_ackout_nxt;
      logic              r_proterr;
      logic              w_proterr_nxt;
      logic              w_err_set;

      // Scan enable has no functional role in this block.
      logic              w_unused_se;
      assign w_unused_se = SE;

      // Multi-flop synchroniser bringing the remote request level into REGCLK.
      always_ff @(posedge REGCLK or posedge RARREGRESET) begin
        if (RARREGRESET) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[L_SYNC-2:0], REQIN};
        end
      end

      assign w_reqs = r_sync[L_SYNC-1];

      // Next-state and next-output decode for the IDLE/VALID/ACK handshake.
      always_comb begin
        w_state_nxt  = r_state;
        w_rdata_nxt  = r_rdata;
        w_rvalid_nxt = r_rvalid;
        w_ackout_nxt = r_ackout;
        w_err_set    = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_reqs) begin
              // Sender keeps DATAIN stable while its request is up, so a
              // direct sample is safe here.
              w_rdata_nxt  = DATAIN;
              w_rvalid_nxt = 1'b1;
              w_ackout_nxt = 1'b0;
              w_state_nxt  = S_VALID;
            end else begin
              w_rvalid_nxt = 1'b0;
              w_ackout_nxt = 1'b0;
              w_state_nxt  = S_IDLE;
            end
          end
          S_VALID: begin
            if (!w_reqs) begin
              // The request was withdrawn before the consumer accepted the
              // data.  Drop the word, flag the error and ignore RREADY.
              w_err_set    = 1'b1;
              w_rvalid_nxt = 1'b0;
              w_ackout_nxt = 1'b0;
              w_state_nxt  = S_IDLE;
            end else if (RREADY) begin
              w_rvalid_nxt = 1'b0;
              w_ackout_nxt = 1'b1;
              w_state_nxt  = S_ACK;
            end else begin
              w_rvalid_nxt = 1'b1;
              w_ackout_nxt = 1'b0;
              w_state_nxt  = S_VALID;
            end
          end
          S_ACK: begin
            if (!w_reqs) begin
              w_rvalid_nxt = 1'b0;
              w_ackout_nxt = 1'b0;
              w_state_nxt  = S_IDLE;
            end else begin
              w_rvalid_nxt = 1'b0;
              w_ackout_nxt = 1'b1;
              w_state_nxt  = S_ACK;
            end
          end
          default: begin
            // Unreachable encoding.  Fall back to a quiet IDLE so that a
            // corrupted state can never hold ACKOUT or RVALID high.
            w_rvalid_nxt = 1'b0;
            w_ackout_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        endcase
      end

      // Sticky error flag.  A new error beats a clear in the same cycle.
      always_comb begin
        if (w_err_set) begin
          w_proterr_nxt = 1'b1;
        end else if (ERRCLR) begin
          w_proterr_nxt = 1'b0;
        end else begin
          w_proterr_nxt = r_proterr;
        end
      end

      // Handshake state, captured data and all output flops.
      always_ff @(posedge REGCLK or posedge RARREGRESET) begin
        if (RARREGRESET) begin
          r_state   <= S_IDLE;
          r_rdata   <= '0;
          r_rvalid  <= 1'b0;
          r_ackout  <= 1'b0;
          r_proterr <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_rdata   <= w_rdata_nxt;
          r_rvalid  <= w_rvalid_nxt;
          r_ackout  <= w_ackout_nxt;
          r_proterr <= w_proterr_nxt;
        end
      end

      // ACKOUT leaves the block straight from its flop, with no logic after it.
      assign RDATA   = r_rdata;
      assign RVALID  = r_rvalid;
      assign ACKOUT  = r_ackout;
      assign PROTERR = r_proterr;

    end else begin : g_absent

      // Block removed: tie every output low and hold no state.
      logic w_unused_inputs;
      assign w_unused_inputs = ^{REGCLK, RARREGRESET, REQIN, DATAIN, SE, RREADY, ERRCLR};

      assign RDATA   = '0;
      assign RVALID  = 1'b0;
      assign ACKOUT  = 1'b0;
      assign PROTERR = 1'b0;

    end
  endgenerate

endmodule
